seg_scan: RTL and testbench
===========================

# seg_scan

Parametrised time-multiplexed 7-segment display driver for the clock/timer designs. Accepts DIGITS packed BCD/hex nibbles and drives one shared segment bus plus one-hot digit selects, one digit per scan slot. Adds a built-in scan prescaler, 8-level brightness (PWM within each slot), per-digit blink, per-digit decimal point and leading-zero blanking. Sits between the time/counter datapath and the board display pins.

## Interface
- DIGITS, 6: number of digits scanned, 2..8.
- SCAN_DIV, 1000: CP cycles per brightness sub-phase, ≥1; one slot = 8 sub-phases.
- BLINK_DIV, 64: full scan frames per blink half-period, ≥1.
- CP  in  1  system clock, all state on rising edge.
- CR  in  1  reset, synchronous, active-low.
- en  in  1  scan enable; 0 blanks the display and holds the counters cleared.
- data  in  4*DIGITS  digit i nibble at [4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS  decimal point request per digit.
- blink  in  DIGITS  blink enable per digit.
- lz_en  in  1  leading-zero blanking enable.
- bright  in  3  brightness 0..7; the digit is lit for bright+1 of 8 sub-phases.
- codeout  out  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered.
- seg  out  DIGITS  one-hot digit select, active-high, registered; bit i selects digit i.

## Operation
- Counters: cnt 0..SCAN_DIV-1; sub 0..7, advances when cnt wraps; idx 0..DIGITS-1, advances when sub wraps from 7 (DIGITS-1 → 0); frame 0..BLINK_DIV-1, advances when idx wraps; blink_ph toggles when frame wraps.
- Scan order: digit 0, 1, …, DIGITS-1, repeat.
- Slot latch: at each slot start (idx change, or the first cycle after reset/en rise) the nibble, dp, blink and blank status of the new digit are captured; changes to data mid-slot take effect only at the next visit.
- Decode: hex 0..F → 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 in bits [6:0]; bit 7 = dp[i].
- Leading-zero blank: digit i (i≥1) is blanked when lz_en=1 and every nibble i..DIGITS-1 is 0; segments [6:0]=0, dp still shown. Digit 0 is never blanked.
- Blink: when blink[i]=1 and blink_ph=1, seg=0 and codeout=0 for that slot.
- Brightness: when sub>bright, seg=0 and codeout=0 (dark sub-phase).
- Outputs are otherwise seg=one-hot(idx), codeout=decoded value.

## Timing
- Reset (CR=0 at an edge): codeout=0, seg=0, cnt=sub=idx=frame=0, blink_ph=0 (visible). Reset mid-slot aborts the slot; display resumes with digit 0.
- en=0: next edge codeout=0, seg=0, all counters 0; en rising restarts at digit 0, sub 0.
- Output latency: one CP; outputs at edge k+1 reflect (idx, sub, blink_ph) held during cycle k.
- Slot length 8·SCAN_DIV cycles; frame 8·SCAN_DIV·DIGITS cycles; blink period 2·BLINK_DIV frames.
- seg is never multi-hot; at a digit change, old and new selects never overlap (both outputs switch on the same edge).
- bright changes take effect on the next sub-phase comparison; no glitch in the current cycle beyond that.

## Structure
- Package seg_pkg: 16-entry hex→segment constant table, segment bit-index constants (SEG_A..SEG_DP), BRIGHT_W=3, SUBPHASES=8.
- One sub-module: seg_hex_decode (4-bit nibble → 7-bit segments, combinational, table from seg_pkg).
- Counters, slot latch, blank logic and output registers in seg_scan.

## Test plan
Bench params DIGITS=6, SCAN_DIV=2, BLINK_DIV=2.
- Reset: CR=0 two cycles → seg=000000, codeout=00; release with en=1, data=0x123456, bright=7 → seg=000001/codeout=7D for 16 cycles, then seg=000010/codeout=6D, …, seg=100000/codeout=06.
- Leading zeros: data=0x000705, lz_en=1 → digits 3..5 show codeout=00 with select asserted, digit 2 shows 07, digit 0 shows 6D; lz_en=0 → digits 3..5 show 3F.
- dp/blink: dp=000100, blink=000001 → digit 2 codeout has bit 7 set; digit 0 dark (seg=0) during alternate 2-frame periods (every 192 cycles).
- Brightness: bright=2 → within each 16-cycle slot select active 6 cycles, zero 10 cycles; bright=0 → 2 cycles lit.
- Mid-slot change and en: change data during digit 0 slot → new value appears only at next digit-0 visit; en=0 mid-slot → seg=0 next edge, en=1 → restarts at digit 0.
- Reset mid-operation at idx=4, sub=5 → next edge outputs 0, counters 0; scan restarts at digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed 7-segment driver.
//   SEG_TABLE  : hex nibble -> segments {g,f,e,d,c,b,a}, active-high.
//   SEG_A..SEG_DP : bit positions inside the 8-bit segment bus.
//   BRIGHT_W   : width of the brightness control.
//   SUBPHASES  : brightness sub-phases per digit slot.
package seg_pkg;

  localparam int BRIGHT_W  = 3;
  localparam int SUBPHASES = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry 15 is listed first so that SEG_TABLE[n] is the pattern for hex n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to 7-segment pattern.
//   nibble   in  4  hex value 0..F
//   segments out 7  {g,f,e,d,c,b,a}, active-high
import seg_pkg::*;

module seg_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed 7-segment display driver.
//   CP       in   clock, all state on rising edge
//   CR       in   synchronous active-low reset
//   en       in   scan enable; low blanks and clears the scan counters
//   data     in   DIGITS packed nibbles, digit i at [4i+3:4i], digit 0 rightmost
//   dp       in   per-digit decimal point request
//   blink    in   per-digit blink enable
//   lz_en    in   leading-zero blanking enable
//   bright   in   brightness 0..7, lit for bright+1 of 8 sub-phases
//   codeout  out  registered segments {dp,g,f,e,d,c,b,a}, active-high
//   seg      out  registered one-hot digit select, active-high
import seg_pkg::*;

module seg_scan #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            codeout,
  output logic [DIGITS-1:0]     seg
);

  localparam int CNT_W   = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int SUB_W   = $clog2(SUBPHASES);
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0]   cnt_reg;
  logic [SUB_W-1:0]   sub_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [FRAME_W-1:0] frame_reg;
  logic               blink_ph_reg;
  // Set during the first cycle of a slot, when the slot latch is still empty.
  logic               first_reg;

  logic [3:0]         nib_reg;
  logic               dp_lat_reg;
  logic               blink_lat_reg;
  logic               blank_reg;

  logic [7:0]         codeout_reg;
  logic [DIGITS-1:0]  seg_reg;

  logic [3:0] nibs [DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nibs[gi] = data[4*gi +: 4];
  end

  // Live view of the digit addressed by idx, used only at slot start.
  logic [3:0] nib_live;
  logic       dp_live;
  logic       blink_live;
  logic       upper_zero;
  logic       blank_live;

  always_comb begin
    nib_live   = 4'd0;
    dp_live    = 1'b0;
    blink_live = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_reg) begin
        nib_live   = nibs[i];
        dp_live    = dp[i];
        blink_live = blink[i];
      end
      if ((IDX_W'(i) >= idx_reg) && (nibs[i] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    blank_live = lz_en && (idx_reg != '0) && upper_zero;
  end

  // On the first cycle of a slot the latch is being loaded, so use live values.
  logic [3:0] nib_eff;
  logic       dp_eff;
  logic       blink_eff;
  logic       blank_eff;

  assign nib_eff   = first_reg ? nib_live   : nib_reg;
  assign dp_eff    = first_reg ? dp_live    : dp_lat_reg;
  assign blink_eff = first_reg ? blink_live : blink_lat_reg;
  assign blank_eff = first_reg ? blank_live : blank_reg;

  logic [6:0] seg7;

  seg_hex_decode u_decode (
    .nibble   (nib_eff),
    .segments (seg7)
  );

  logic              lit;
  logic [DIGITS-1:0] onehot;
  logic [7:0]        code_next;

  assign lit    = (sub_reg <= bright) && !(blink_eff && blink_ph_reg);
  assign onehot = DIGITS'(1) << idx_reg;

  always_comb begin
    code_next = 8'd0;
    if (lit) begin
      code_next[SEG_DP]   = dp_eff;
      code_next[SEG_G:0]  = blank_eff ? 7'd0 : seg7;
    end
  end

  logic cnt_wrap;
  logic sub_wrap;
  logic idx_wrap;
  logic frame_wrap;

  assign cnt_wrap   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign sub_wrap   = cnt_wrap && (sub_reg == SUB_W'(SUBPHASES - 1));
  assign idx_wrap   = sub_wrap && (idx_reg == IDX_W'(DIGITS - 1));
  assign frame_wrap = idx_wrap && (frame_reg == FRAME_W'(BLINK_DIV - 1));

  always_ff @(posedge CP) begin
    if (!CR || !en) begin
      cnt_reg       <= '0;
      sub_reg       <= '0;
      idx_reg       <= '0;
      frame_reg     <= '0;
      blink_ph_reg  <= 1'b0;
      first_reg     <= 1'b1;
      nib_reg       <= 4'd0;
      dp_lat_reg    <= 1'b0;
      blink_lat_reg <= 1'b0;
      blank_reg     <= 1'b0;
      codeout_reg   <= 8'd0;
      seg_reg       <= '0;
    end else begin
      codeout_reg <= code_next;
      seg_reg     <= lit ? onehot : '0;

      first_reg <= 1'b0;
      if (first_reg) begin
        nib_reg       <= nib_live;
        dp_lat_reg    <= dp_live;
        blink_lat_reg <= blink_live;
        blank_reg     <= blank_live;
      end

      cnt_reg <= cnt_wrap ? '0 : cnt_reg + 1'b1;
      if (cnt_wrap) begin
        sub_reg <= sub_wrap ? '0 : sub_reg + 1'b1;
      end
      if (sub_wrap) begin
        idx_reg   <= idx_wrap ? '0 : idx_reg + 1'b1;
        first_reg <= 1'b1;
      end
      if (idx_wrap) begin
        frame_reg <= frame_wrap ? '0 : frame_reg + 1'b1;
      end
      if (frame_wrap) begin
        blink_ph_reg <= !blink_ph_reg;
      end
    end
  end

  assign codeout = codeout_reg;
  assign seg     = seg_reg;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed self-checking bench for seg_scan
// (DIGITS=6, SCAN_DIV=2, BLINK_DIV=2: 16-cycle slots, 96-cycle frames).
module tb_seg_scan;

  logic        CP = 1'b0;
  logic        CR;
  logic        en;
  logic [23:0] data;
  logic [5:0]  dp;
  logic [5:0]  blink;
  logic        lz_en;
  logic [2:0]  bright;
  logic [7:0]  codeout;
  logic [5:0]  seg;

  int checks = 0;
  int errors = 0;

  seg_scan #(
    .DIGITS    (6),
    .SCAN_DIV  (2),
    .BLINK_DIV (2)
  ) dut (
    .CP      (CP),
    .CR      (CR),
    .en      (en),
    .data    (data),
    .dp      (dp),
    .blink   (blink),
    .lz_en   (lz_en),
    .bright  (bright),
    .codeout (codeout),
    .seg     (seg)
  );

  always #5 CP = ~CP;

  // One cycle of a slot: digit d, cycle c (0..15) within the slot.
  task automatic check_cycle(input string tag, input int d, input int c,
                             input logic [7:0] code, input int br, input bit dark);
    logic [5:0] s_exp;
    logic [7:0] c_exp;
    bit         lit;
    @(negedge CP);
    lit   = ((c / 2) <= br) && !dark;
    s_exp = lit ? 6'(1 << d) : 6'd0;
    c_exp = lit ? code : 8'h00;
    checks++;
    assert (seg === s_exp && codeout === c_exp) else begin
      errors++;
      $error("FAIL %s d%0d c%0d: seg=%b codeout=%h, expected seg=%b codeout=%h",
             tag, d, c, seg, codeout, s_exp, c_exp);
    end
  endtask

  task automatic check_slot(input string tag, input int d, input logic [7:0] code,
                            input int br, input bit dark);
    for (int c = 0; c < 16; c++) check_cycle(tag, d, c, code, br, dark);
  endtask

  // codes packs the expected codeout per digit, digit d at [8d+7:8d].
  task automatic scan_frame(input string tag, input logic [47:0] codes,
                            input int br, input logic [5:0] dark);
    for (int d = 0; d < 6; d++) check_slot(tag, d, codes[d*8 +: 8], br, dark[d]);
  endtask

  task automatic check_zero(input string tag);
    @(negedge CP);
    checks++;
    assert (seg === 6'd0 && codeout === 8'h00) else begin
      errors++;
      $error("FAIL %s: seg=%b codeout=%h, expected seg=000000 codeout=00",
             tag, seg, codeout);
    end
  endtask

  // Pulse en low for one cycle so the scan restarts at digit 0, sub 0.
  task automatic restart();
    en = 1'b0;
    check_zero("en_low");
    en = 1'b1;
  endtask

  initial begin
    CR = 1'b0; en = 1'b0; data = 24'h0; dp = 6'd0; blink = 6'd0;
    lz_en = 1'b0; bright = 3'd7;

    check_zero("reset_0");
    check_zero("reset_1");

    // 0x123456: 6->7D 5->6D 4->66 3->4F 2->5B 1->06
    CR = 1'b1; en = 1'b1; data = 24'h123456;
    scan_frame("scan_123456", 48'h065B4F666D7D, 7, 6'd0);

    // Leading-zero blanking: digits 3..5 blank, digit 1 zero but shown.
    data = 24'h000705; lz_en = 1'b1;
    restart();
    scan_frame("lz_on", 48'h000000073F6D, 7, 6'd0);
    lz_en = 1'b0;
    restart();
    scan_frame("lz_off", 48'h3F3F3F073F6D, 7, 6'd0);

    // Decimal point on digit 2, blink on digit 0: dark in frames 2 and 3.
    data = 24'h123456; dp = 6'b000100; blink = 6'b000001;
    restart();
    scan_frame("blink_f0", 48'h065B4FE66D7D, 7, 6'd0);
    scan_frame("blink_f1", 48'h065B4FE66D7D, 7, 6'd0);
    scan_frame("blink_f2", 48'h065B4FE66D7D, 7, 6'b000001);
    scan_frame("blink_f3", 48'h065B4FE66D7D, 7, 6'b000001);
    scan_frame("blink_f4", 48'h065B4FE66D7D, 7, 6'd0);

    // Brightness: 6 of 16 cycles lit, then 2 of 16.
    dp = 6'd0; blink = 6'd0; bright = 3'd2;
    restart();
    scan_frame("bright2", 48'h065B4F666D7D, 2, 6'd0);
    bright = 3'd0;
    scan_frame("bright0", 48'h065B4F666D7D, 0, 6'd0);

    // Mid-slot data change only shows at the next visit of digit 0.
    bright = 3'd7;
    restart();
    for (int c = 0; c < 8; c++) check_cycle("midslot_old", 0, c, 8'h7D, 7, 1'b0);
    data = 24'h123450;
    for (int c = 8; c < 16; c++) check_cycle("midslot_hold", 0, c, 8'h7D, 7, 1'b0);
    for (int d = 1; d < 6; d++) check_slot("midslot_rest", d, (d == 1) ? 8'h6D :
                                           (d == 2) ? 8'h66 : (d == 3) ? 8'h4F :
                                           (d == 4) ? 8'h5B : 8'h06, 7, 1'b0);
    check_slot("midslot_new", 0, 8'h3F, 7, 1'b0);

    // en low in the middle of digit 1 blanks at once; en high restarts at digit 0.
    for (int c = 0; c < 6; c++) check_cycle("en_mid_pre", 1, c, 8'h6D, 7, 1'b0);
    en = 1'b0;
    check_zero("en_mid_off");
    en = 1'b1;
    check_slot("en_mid_restart", 0, 8'h3F, 7, 1'b0);
    check_slot("en_mid_next", 1, 8'h6D, 7, 1'b0);

    // Reset in the middle of digit 4 (sub 5).
    data = 24'h123456;
    restart();
    for (int d = 0; d < 4; d++) check_slot("rst_mid_pre", d, (d == 0) ? 8'h7D :
                                           (d == 1) ? 8'h6D : (d == 2) ? 8'h66 : 8'h4F,
                                           7, 1'b0);
    for (int c = 0; c < 10; c++) check_cycle("rst_mid_d4", 4, c, 8'h5B, 7, 1'b0);
    CR = 1'b0;
    check_zero("rst_mid_0");
    check_zero("rst_mid_1");
    CR = 1'b1;
    scan_frame("rst_mid_resume", 48'h065B4F666D7D, 7, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
